// File: rtl/reg_based_tcam_prio.sv
// reg_based_tcam_prio: register TCAM with per-entry valid, single-cycle flush and a 2-stage priority-encoded lookup
module reg_based_tcam_prio #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int WORDS = 1 << ADDR_WIDTH,
  parameter bit PRIORITY_LOW = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wena,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] wcare,
  input  logic                  wvalid,
  input  logic                  clear_all,
  input  logic                  lookup_valid,
  input  logic [DATA_WIDTH-1:0] lookup_data,
  output logic                  out_valid,
  output logic [WORDS-1:0]      match_lines,
  output logic                  hit,
  output logic                  multi_hit,
  output logic [ADDR_WIDTH-1:0] match_addr
);
  logic [DATA_WIDTH-1:0] data [WORDS];
  logic [DATA_WIDTH-1:0] care [WORDS];
  logic [WORDS-1:0] valid;
  logic [WORDS-1:0] match;
  logic [WORDS-1:0] s1_match;
  logic s1_valid;
  logic [ADDR_WIDTH-1:0] enc;
  always_ff @(posedge clk)
    if (wena && !clear_all && !rst) begin
      data[waddr] <= wdata;
      care[waddr] <= wcare;
    end
  always_ff @(posedge clk)
    if (rst || clear_all) valid <= '0;
    else if (wena) valid[waddr] <= wvalid;
  always_comb begin
    match = '0;
    for (int i = 0; i < WORDS; i++)
      match[i] = valid[i] && (((lookup_data ^ data[i]) & care[i]) == '0);
  end
  // scan toward the winning end so the last assignment is the preferred index
  always_comb begin
    enc = '0;
    for (int i = 0; i < WORDS; i++)
      if (s1_match[PRIORITY_LOW ? WORDS-1-i : i]) enc = ADDR_WIDTH'(PRIORITY_LOW ? WORDS-1-i : i);
  end
  always_ff @(posedge clk)
    if (rst) begin
      s1_valid <= 1'b0;
      s1_match <= '0;
      out_valid <= 1'b0;
      match_lines <= '0;
      hit <= 1'b0;
      multi_hit <= 1'b0;
      match_addr <= '0;
    end else begin
      s1_valid <= lookup_valid;
      s1_match <= match;
      out_valid <= s1_valid;
      match_lines <= s1_match;
      hit <= |s1_match;
      multi_hit <= |(s1_match & (s1_match - WORDS'(1)));
      match_addr <= enc;
    end
endmodule

// File: tb/tb_reg_based_tcam_prio.sv
// tb_reg_based_tcam_prio: randomized and directed checks of both priority polarities against a table model
module tb_reg_based_tcam_prio;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int W = 16;
  typedef logic [45:0] res_t;
  logic clk = 0, rst = 1, wena = 0, wvalid = 0, clear_all = 0, lookup_valid = 0;
  logic [AW-1:0] waddr = '0;
  logic [DW-1:0] wdata = '0, wcare = '0, lookup_data = '0;
  logic ov, hit, mh, h_ov, h_hit, h_mh;
  logic [W-1:0] ml, h_ml;
  logic [AW-1:0] addr, h_addr;
  res_t obs;
  logic [DW-1:0] md [W];
  logic [DW-1:0] mc [W];
  bit mv [W];
  int tests = 0, fails = 0;

  assign obs = {ov, ml, hit, mh, addr, h_ov, h_ml, h_hit, h_mh, h_addr};
  always #5 clk = ~clk;

  reg_based_tcam_prio #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PRIORITY_LOW(1)) dut (
    .clk(clk), .rst(rst), .wena(wena), .waddr(waddr), .wdata(wdata), .wcare(wcare),
    .wvalid(wvalid), .clear_all(clear_all), .lookup_valid(lookup_valid), .lookup_data(lookup_data),
    .out_valid(ov), .match_lines(ml), .hit(hit), .multi_hit(mh), .match_addr(addr));
  reg_based_tcam_prio #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PRIORITY_LOW(0)) dut_hi (
    .clk(clk), .rst(rst), .wena(wena), .waddr(waddr), .wdata(wdata), .wcare(wcare),
    .wvalid(wvalid), .clear_all(clear_all), .lookup_valid(lookup_valid), .lookup_data(lookup_data),
    .out_valid(h_ov), .match_lines(h_ml), .hit(h_hit), .multi_hit(h_mh), .match_addr(h_addr));

  function automatic res_t expect_of(input logic [DW-1:0] key);
    logic [W-1:0] m;
    int lo, hi;
    logic lh, lm;
    m = '0;
    lo = 0;
    hi = 0;
    for (int i = 0; i < W; i++) m[i] = mv[i] && (((key ^ md[i]) & mc[i]) == 0);
    for (int i = W - 1; i >= 0; i--) if (m[i]) lo = i;
    for (int i = 0; i < W; i++) if (m[i]) hi = i;
    lh = m != 0;
    lm = $countones(m) >= 2;
    return {1'b1, m, lh, lm, 4'(lo), 1'b1, m, lh, lm, 4'(hi)};
  endfunction

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW-1:0] c, input bit v);
    @(negedge clk);
    lookup_valid = 0;
    wena = 1; waddr = a; wdata = d; wcare = c; wvalid = v;
    md[a] = d; mc[a] = c; mv[a] = v;
  endtask

  task automatic lookup(input logic [DW-1:0] key, output res_t o, output logic [1:0] lat);
    @(negedge clk);
    wena = 0; clear_all = 0;
    lookup_valid = 1; lookup_data = key;
    @(negedge clk);
    lookup_valid = 0;
    lat[1] = ov | h_ov;
    @(negedge clk);
    o = obs;
    @(negedge clk);
    lat[0] = ov | h_ov;
  endtask

  task automatic load();
    do_write(0, 32'h12340000, 32'hffff0000, 1);
    do_write(1, 32'h12345000, 32'hfffff000, 1);
    do_write(2, 32'habcd0000, 32'hffff0000, 1);
    do_write(9, 32'hef000000, 32'hfff00000, 1);
  endtask

  task automatic test_reset();
    res_t o, e;
    logic [1:0] lat;
    repeat (3) @(negedge clk);
    tests++;
    if (obs !== '0) begin fails++; $display("FAIL reset_outputs got=%h exp=0", obs); end
    rst = 0;
    e = expect_of(32'h12345abc);
    lookup(32'h12345abc, o, lat);
    tests++;
    if (o !== e) begin fails++; $display("FAIL reset_empty got=%h exp=%h", o, e); end
  endtask

  task automatic test_basic();
    logic [DW-1:0] keys [4];
    res_t o, e;
    logic [1:0] lat;
    keys = '{32'h12345abc, 32'habcd2341, 32'hef012000, 32'h55555555};
    load();
    for (int k = 0; k < 4; k++) begin
      e = expect_of(keys[k]);
      lookup(keys[k], o, lat);
      tests++;
      if (o !== e) begin fails++; $display("FAIL basic key=%h got=%h exp=%h", keys[k], o, e); end
      tests++;
      if (lat !== 2'b00) begin fails++; $display("FAIL latency key=%h got=%b exp=00", keys[k], lat); end
    end
  endtask

  task automatic test_priority();
    res_t o, e;
    logic [1:0] lat;
    do_write(0, 32'h12340000, 32'hffff0000, 0);
    e = expect_of(32'h12345abc);
    lookup(32'h12345abc, o, lat);
    tests++;
    if (o !== e) begin fails++; $display("FAIL invalidate got=%h exp=%h", o, e); end
    do_write(0, 32'h12340000, 32'hffff0000, 1);
    e = expect_of(32'h12345abc);
    lookup(32'h12345abc, o, lat);
    tests++;
    if (o !== e) begin fails++; $display("FAIL priority got=%h exp=%h", o, e); end
  endtask

  task automatic test_same_edge();
    res_t e1, e2;
    @(negedge clk);
    wena = 1; waddr = 5; wdata = 32'h77770000; wcare = 32'hffff0000; wvalid = 1;
    lookup_valid = 1; lookup_data = 32'h77770000;
    e1 = expect_of(32'h77770000);
    md[5] = 32'h77770000; mc[5] = 32'hffff0000; mv[5] = 1;
    @(negedge clk);
    wena = 0;
    e2 = expect_of(32'h77770000);
    @(negedge clk);
    lookup_valid = 0;
    tests++;
    if (obs !== e1) begin fails++; $display("FAIL same_edge got=%h exp=%h", obs, e1); end
    @(negedge clk);
    tests++;
    if (obs !== e2) begin fails++; $display("FAIL next_cycle got=%h exp=%h", obs, e2); end
  endtask

  task automatic test_clear();
    res_t o, e;
    logic [1:0] lat;
    @(negedge clk);
    clear_all = 1;
    wena = 1; waddr = 3; wdata = '0; wcare = '0; wvalid = 1;
    for (int i = 0; i < W; i++) mv[i] = 0;
    e = expect_of(32'h12345abc);
    lookup(32'h12345abc, o, lat);
    tests++;
    if (o !== e) begin fails++; $display("FAIL clear_lookup got=%h exp=%h", o, e); end
    e = expect_of(32'h0);
    lookup(32'h0, o, lat);
    tests++;
    if (o !== e) begin fails++; $display("FAIL clear_dropped_write got=%h exp=%h", o, e); end
    load();
  endtask

  task automatic test_back_to_back();
    res_t q [$];
    res_t e;
    logic [DW-1:0] pool [4];
    logic [DW-1:0] key;
    pool = '{32'h12345abc, 32'habcd2341, 32'hef012000, 32'h1234ffff};
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      wena = 0;
      if (c >= 2) begin
        e = q.pop_front();
        tests++;
        if (obs !== e) begin fails++; $display("FAIL back_to_back slot=%0d got=%h exp=%h", c - 2, obs, e); end
      end
      if (c < 8) begin
        key = $urandom_range(1) ? pool[$urandom_range(3)] : $urandom;
        lookup_valid = 1; lookup_data = key;
        q.push_back(expect_of(key));
      end else lookup_valid = 0;
    end
  endtask

  task automatic test_reset_flight();
    res_t o, e;
    logic [1:0] lat;
    @(negedge clk);
    lookup_valid = 1; lookup_data = 32'h12345abc;
    @(negedge clk);
    lookup_data = 32'habcd2341; rst = 1;
    for (int i = 0; i < W; i++) mv[i] = 0;
    @(negedge clk);
    lookup_valid = 0; rst = 0;
    for (int c = 0; c < 3; c++) begin
      tests++;
      if (obs !== '0) begin fails++; $display("FAIL reset_flight cycle=%0d got=%h exp=0", c, obs); end
      @(negedge clk);
    end
    e = expect_of(32'h12345abc);
    lookup(32'h12345abc, o, lat);
    tests++;
    if (o !== e) begin fails++; $display("FAIL post_reset got=%h exp=%h", o, e); end
  endtask

  task automatic test_edge();
    logic [DW-1:0] keys [4];
    res_t o, e;
    logic [1:0] lat;
    keys = '{32'haaaaaaaa, 32'haaaaaaab, 32'h22222222, 32'h11111111};
    load();
    do_write(15, 32'haaaaaaaa, 32'hffffffff, 1);
    for (int k = 0; k < 4; k++) begin
      if (k == 2) begin
        do_write(15, 32'h11111111, 32'hffffffff, 1);
        do_write(15, 32'h22222222, 32'hffffffff, 1);
      end
      e = expect_of(keys[k]);
      lookup(keys[k], o, lat);
      tests++;
      if (o !== e) begin fails++; $display("FAIL edge key=%h got=%h exp=%h", keys[k], o, e); end
    end
  endtask

  task automatic test_random();
    res_t o, e;
    logic [1:0] lat;
    logic [DW-1:0] key, c;
    int idx;
    for (int n = 0; n < 40; n++) begin
      c = $urandom_range(7) == 0 ? '0 : ($urandom | $urandom);
      do_write(AW'($urandom_range(W - 1)), $urandom, c, $urandom_range(3) != 0);
      idx = $urandom_range(W - 1);
      key = md[idx] ^ ($urandom & ~mc[idx]);
      if ($urandom_range(3) == 0) key = key ^ (32'h1 << $urandom_range(31));
      e = expect_of(key);
      lookup(key, o, lat);
      tests++;
      if (o !== e) begin fails++; $display("FAIL random n=%0d key=%h got=%h exp=%h", n, key, o, e); end
    end
  endtask

  initial begin
    for (int i = 0; i < W; i++) begin md[i] = '0; mc[i] = '0; mv[i] = 0; end
    test_reset();
    test_basic();
    test_priority();
    test_same_edge();
    test_clear();
    test_back_to_back();
    test_reset_flight();
    test_edge();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
